// File: rtl/drink_dispense_arb_if.sv
// Panel-side bus of the drink dispense arbiter: requests and latched service
// parameters in, grant/drive/status out.
interface drink_dispense_arb_if;
  logic       ena;
  logic [1:0] req;
  logic [1:0] cnt0;
  logic [1:0] cnt1;
  logic [1:0] chg;
  logic [1:0] gnt;
  logic       motor;
  logic       half_out;
  logic [1:0] done;
  logic       busy;
  logic [2:0] state;
  logic [7:0] served;

  modport master (
    output ena, req, cnt0, cnt1, chg,
    input  gnt, motor, half_out, done, busy, state, served
  );

  modport slave (
    input  ena, req, cnt0, cnt1, chg,
    output gnt, motor, half_out, done, busy, state, served
  );
endinterface

// File: rtl/drink_dispense_arb.sv
// Round-robin arbiter/sequencer sharing one dispense motor and change chute
// between two coin panels; every output is a register.
module drink_dispense_arb #(
  parameter int MOTOR_CYC = 4,
  parameter int GAP_CYC   = 2,
  parameter int CHG_CYC   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  drink_dispense_arb_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GRANT  = 3'd1,
    MOTOR  = 3'd2,
    GAP    = 3'd3,
    CHANGE = 3'd4,
    DONE   = 3'd5
  } state_t;

  // Counter reload values: a phase lasts until the counter has counted down to 0.
  localparam logic [7:0] MOTOR_LOAD = 8'(MOTOR_CYC - 1);
  localparam logic [7:0] GAP_LOAD   = 8'(GAP_CYC - 1);
  localparam logic [7:0] CHG_LOAD   = 8'(CHG_CYC - 1);

  state_t     st;
  logic [1:0] gnt_r;
  logic       motor_r;
  logic       half_r;
  logic [1:0] done_r;
  logic       busy_r;
  logic [7:0] served_r;
  logic       ptr;
  logic       win;
  logic [7:0] cyc;
  logic [1:0] rem;
  logic       chg_l;
  logic       pick;

  function automatic logic [1:0] onehot(input logic w);
    return w ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // A lone request wins outright; a tie goes to the round-robin pointer.
  assign pick = (bus.req == 2'b10) ? 1'b1 :
                (bus.req == 2'b01) ? 1'b0 : ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      st       <= IDLE;
      gnt_r    <= 2'b00;
      motor_r  <= 1'b0;
      half_r   <= 1'b0;
      done_r   <= 2'b00;
      busy_r   <= 1'b0;
      served_r <= 8'd0;
      ptr      <= 1'b0;
      win      <= 1'b0;
      cyc      <= 8'd0;
      rem      <= 2'd0;
      chg_l    <= 1'b0;
    end else begin
      done_r <= 2'b00;
      unique case (st)
        IDLE: begin
          if (bus.ena && (bus.req != 2'b00)) begin
            win    <= pick;
            rem    <= pick ? bus.cnt1 : bus.cnt0;
            chg_l  <= bus.chg[pick];
            gnt_r  <= onehot(pick);
            busy_r <= 1'b1;
            st     <= GRANT;
          end
        end
        GRANT: begin
          if (rem != 2'd0) begin
            cyc     <= MOTOR_LOAD;
            motor_r <= 1'b1;
            st      <= MOTOR;
          end else if (chg_l) begin
            cyc    <= CHG_LOAD;
            half_r <= 1'b1;
            st     <= CHANGE;
          end else begin
            done_r <= onehot(win);
            st     <= DONE;
          end
        end
        MOTOR: begin
          if (cyc == 8'd0) begin
            rem      <= rem - 2'd1;
            served_r <= sat_inc(served_r);
            motor_r  <= 1'b0;
            if (rem == 2'd1) begin
              if (chg_l) begin
                cyc    <= CHG_LOAD;
                half_r <= 1'b1;
                st     <= CHANGE;
              end else begin
                done_r <= onehot(win);
                st     <= DONE;
              end
            end else begin
              cyc <= GAP_LOAD;
              st  <= GAP;
            end
          end else begin
            cyc <= cyc - 8'd1;
          end
        end
        GAP: begin
          if (cyc == 8'd0) begin
            cyc     <= MOTOR_LOAD;
            motor_r <= 1'b1;
            st      <= MOTOR;
          end else begin
            cyc <= cyc - 8'd1;
          end
        end
        CHANGE: begin
          if (cyc == 8'd0) begin
            half_r <= 1'b0;
            done_r <= onehot(win);
            st     <= DONE;
          end else begin
            cyc <= cyc - 8'd1;
          end
        end
        DONE: begin
          ptr    <= ~win;
          gnt_r  <= 2'b00;
          busy_r <= 1'b0;
          st     <= IDLE;
        end
        default: begin
          gnt_r   <= 2'b00;
          motor_r <= 1'b0;
          half_r  <= 1'b0;
          busy_r  <= 1'b0;
          st      <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt      = gnt_r;
  assign bus.motor    = motor_r;
  assign bus.half_out = half_r;
  assign bus.done     = done_r;
  assign bus.busy     = busy_r;
  assign bus.state    = st;
  assign bus.served   = served_r;

endmodule

// File: tb/tb_drink_dispense_arb.sv
// Scoreboard bench for drink_dispense_arb: expected service records are queued
// when a request is driven and compared against records built by a bus monitor.
module tb_drink_dispense_arb;

  typedef struct packed {
    logic [1:0] gnt;
    logic [1:0] done;
    logic [7:0] mot;
    logic [7:0] pulses;
    logic [7:0] half;
    logic [7:0] len;
    logic [7:0] served;
    logic       gbad;
  } svc_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rst_f = 1'b1;
  always #5 clk = ~clk;

  drink_dispense_arb_if b ();
  drink_dispense_arb_if bf ();

  drink_dispense_arb dut (.clk(clk), .reset(reset), .bus(b));
  drink_dispense_arb #(.MOTOR_CYC(1), .GAP_CYC(1), .CHG_CYC(2)) dut_f (.clk(clk), .reset(rst_f), .bus(bf));

  int checks = 0;
  int failures = 0;
  int model_served = 0;
  svc_t exp_q[$];
  svc_t obs_q[$];
  logic [7:0] fexp_q[$];

  // Bus monitor: builds one record per service from GRANT through DONE.
  bit   act = 1'b0;
  logic prev_mot = 1'b0;
  svc_t m;
  always @(negedge clk) begin
    if (b.state == 3'd0) begin
      act = 1'b0;
    end else begin
      if (b.state == 3'd1) begin
        act = 1'b1;
        m = '0;
        m.gnt = b.gnt;
        m.len = 8'd1;
      end else if (act) begin
        m.len = m.len + 8'd1;
      end
      if (act) begin
        if (b.gnt !== m.gnt) m.gbad = 1'b1;
        if (b.motor === 1'b1) begin
          m.mot = m.mot + 8'd1;
          if (prev_mot !== 1'b1) m.pulses = m.pulses + 8'd1;
        end
        if (b.half_out === 1'b1) m.half = m.half + 8'd1;
        if (b.state == 3'd5) begin
          m.done = b.done;
          m.served = b.served;
          obs_q.push_back(m);
          act = 1'b0;
        end
      end
    end
    prev_mot = b.motor;
  end

  function automatic string fmt(input svc_t s);
    return $sformatf("gnt=%b done=%b mot=%0d pulses=%0d half=%0d len=%0d served=%0d gbad=%b",
                     s.gnt, s.done, s.mot, s.pulses, s.half, s.len, s.served, s.gbad);
  endfunction

  function automatic svc_t mk_exp(input bit p, input int n, input bit c,
                                  input int mc, input int gc, input int cc);
    svc_t e;
    int s;
    e = '0;
    e.gnt = p ? 2'b10 : 2'b01;
    e.done = e.gnt;
    e.mot = 8'(n * mc);
    e.pulses = 8'(n);
    e.half = c ? 8'(cc) : 8'd0;
    e.len = (n > 0) ? 8'(1 + n * mc + (n - 1) * gc + (c ? cc : 0) + 1)
                    : 8'(1 + (c ? cc : 0) + 1);
    s = model_served + n;
    if (s > 255) s = 255;
    model_served = s;
    e.served = 8'(s);
    return e;
  endfunction

  task automatic drive_req(input bit p, input logic [1:0] n, input bit c);
    @(negedge clk);
    if (p) b.cnt1 = n; else b.cnt0 = n;
    b.chg[p] = c;
    b.req[p] = 1'b1;
  endtask

  // Waits for the grant, then drops req and scrambles cnt/chg, which must be ignored.
  task automatic drop_after_grant(output bit got);
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (b.gnt != 2'b00) begin got = 1'b1; break; end
    end
    b.req = 2'b00;
    b.cnt0 = 2'd3;
    b.cnt1 = 2'd3;
    b.chg = ~b.chg;
  endtask

  task automatic wait_obs(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (obs_q.size() > 0) begin got = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    b.ena = 1'b1; b.req = 2'b11; b.cnt0 = 2'd2; b.cnt1 = 2'd2; b.chg = 2'b11;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({b.gnt, b.motor, b.half_out, b.done, b.busy, b.state, b.served} !== 17'd0) begin
        failures++;
        $display("FAIL reset_c%0d got gnt=%b motor=%b half=%b done=%b busy=%b state=%0d served=%0d want all 0",
                 i, b.gnt, b.motor, b.half_out, b.done, b.busy, b.state, b.served);
      end
    end
    @(negedge clk);
    reset = 1'b0; b.req = 2'b00; b.chg = 2'b00;
    model_served = 0;
  endtask

  task automatic test_single();
    svc_t e, o;
    bit got;
    exp_q.push_back(mk_exp(1'b0, 2, 1'b1, 4, 2, 2));
    drive_req(1'b0, 2'd2, 1'b1);
    @(negedge clk);
    checks++;
    if (b.state !== 3'd1 || b.gnt !== 2'b01) begin
      failures++;
      $display("FAIL grant_latency got state=%0d gnt=%b want state=1 gnt=01", b.state, b.gnt);
    end
    b.req = 2'b00; b.cnt0 = 2'd3; b.chg = 2'b00;
    wait_obs(60, got);
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL single_timeout got no done want done=01");
    end else begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      if (o !== e) begin
        failures++;
        $display("FAIL single got %s want %s", fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_round_robin();
    svc_t e, o;
    bit got;
    bit p;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    model_served = 0;
    b.cnt0 = 2'd1; b.cnt1 = 2'd1; b.chg = 2'b00;
    for (int k = 0; k < 4; k++) exp_q.push_back(mk_exp(k[0], 1, 1'b0, 4, 2, 2));
    @(negedge clk); b.req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      p = k[0];
      wait_obs(40, got);
      checks++;
      if (!got) begin
        failures++;
        $display("FAIL rr%0d_timeout got no done", k);
        void'(exp_q.pop_front());
      end else begin
        o = obs_q.pop_front(); e = exp_q.pop_front();
        if (o !== e) begin
          failures++;
          $display("FAIL rr%0d got %s want %s", k, fmt(o), fmt(e));
        end
      end
      if (k == 3) begin
        b.req = 2'b00;
      end else begin
        b.req[p] = 1'b0;
        @(negedge clk);
        b.req[p] = 1'b1;
      end
    end
  endtask

  task automatic test_zero_count();
    svc_t e, o;
    bit got;
    exp_q.push_back(mk_exp(1'b1, 0, 1'b1, 4, 2, 2));
    drive_req(1'b1, 2'd0, 1'b1);
    drop_after_grant(got);
    wait_obs(30, got);
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL change_only_timeout got no done want done=10");
    end else begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      if (o !== e) begin
        failures++;
        $display("FAIL change_only got %s want %s", fmt(o), fmt(e));
      end
    end
    exp_q.push_back(mk_exp(1'b0, 0, 1'b0, 4, 2, 2));
    drive_req(1'b0, 2'd0, 1'b0);
    checks++;
    if (b.state !== 3'd0) begin
      failures++;
      $display("FAIL empty_idle got state=%0d want 0", b.state);
    end
    @(negedge clk);
    b.req = 2'b00;
    checks++;
    if (b.state !== 3'd1) begin
      failures++;
      $display("FAIL empty_grant got state=%0d want 1", b.state);
    end
    @(negedge clk);
    checks++;
    if (b.state !== 3'd5 || b.done !== 2'b01) begin
      failures++;
      $display("FAIL empty_done got state=%0d done=%b want state=5 done=01", b.state, b.done);
    end
    #1;
    checks++;
    if (obs_q.size() == 0) begin
      failures++;
      $display("FAIL empty_record got none want one");
    end else begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      if (o !== e) begin
        failures++;
        $display("FAIL empty_svc got %s want %s", fmt(o), fmt(e));
      end
    end
    @(negedge clk);
    checks++;
    if (b.state !== 3'd0 || b.done !== 2'b00) begin
      failures++;
      $display("FAIL empty_back_idle got state=%0d done=%b want state=0 done=00", b.state, b.done);
    end
  endtask

  task automatic test_abort_enable();
    svc_t e, o;
    bit got;
    int bad;
    drive_req(1'b0, 2'd2, 1'b0);
    drop_after_grant(got);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (b.state !== 3'd2 || b.motor !== 1'b1) begin
      failures++;
      $display("FAIL abort_setup got state=%0d motor=%b want state=2 motor=1", b.state, b.motor);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_served = 0;
    checks++;
    if ({b.motor, b.half_out, b.state, b.served, b.busy, b.gnt} !== 16'd0) begin
      failures++;
      $display("FAIL abort got motor=%b state=%0d served=%0d busy=%b gnt=%b want all 0",
               b.motor, b.state, b.served, b.busy, b.gnt);
    end
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (b.done !== 2'b00) bad++;
    end
    #1;
    checks++;
    if (bad != 0 || obs_q.size() != 0) begin
      failures++;
      $display("FAIL abort_no_done got stray_done=%0d records=%0d want 0 0", bad, obs_q.size());
    end
    b.ena = 1'b0; b.req = 2'b01; b.cnt0 = 2'd1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (b.gnt !== 2'b00 || b.state !== 3'd0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL ena_low got %0d cycles granted want 0", bad);
    end
    b.req = 2'b00; b.ena = 1'b1;
    exp_q.push_back(mk_exp(1'b0, 2, 1'b0, 4, 2, 2));
    drive_req(1'b0, 2'd2, 1'b0);
    drop_after_grant(got);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (b.state == 3'd3) begin got = 1'b1; break; end
      @(negedge clk);
    end
    b.ena = 1'b0;
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL gap_reach got state=%0d want 3", b.state);
    end
    wait_obs(30, got);
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL ena_gap_timeout got no done want done=01");
    end else begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      if (o !== e) begin
        failures++;
        $display("FAIL ena_gap got %s want %s", fmt(o), fmt(e));
      end
    end
    b.req = 2'b01;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (b.state !== 3'd0 || b.gnt !== 2'b00) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL park got %0d non-idle cycles want 0", bad);
    end
    b.req = 2'b00; b.ena = 1'b1;
  endtask

  task automatic test_saturation();
    int fs;
    bit got;
    logic [7:0] ev;
    fs = 0;
    bf.ena = 1'b1; bf.req = 2'b00; bf.cnt0 = 2'd2; bf.cnt1 = 2'd0; bf.chg = 2'b00;
    @(negedge clk); rst_f = 1'b0;
    for (int k = 0; k < 131; k++) begin
      fs = fs + 2;
      if (fs > 255) fs = 255;
      fexp_q.push_back(8'(fs));
      @(negedge clk); bf.req = 2'b01;
      @(negedge clk); bf.req = 2'b00;
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (bf.done != 2'b00) begin got = 1'b1; break; end
      end
      ev = fexp_q.pop_front();
      checks++;
      if (!got || bf.served !== ev) begin
        failures++;
        $display("FAIL sat_svc%0d got done=%b served=%0d want done=01 served=%0d", k, bf.done, bf.served, ev);
      end
    end
  endtask

  initial begin
    bf.ena = 1'b0; bf.req = 2'b00; bf.cnt0 = 2'd0; bf.cnt1 = 2'd0; bf.chg = 2'b00;
    test_reset();
    test_single();
    test_round_robin();
    test_zero_count();
    test_abort_enable();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
